mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered signed 4x4 multiplier datapath among `N_REQ` requesters. Each requester presents a signed operand pair with a valid/ready handshake. The block grants one request at a time, computes the full 8-bit signed product, and returns it with the winner's ID on a single valid/ready response channel. It sits between the requesting engines and the multiplier datapath, and is the only path into that datapath.

---
 rtl/mul_share_pkg.sv | 17 +
 rtl/mul_share_arb_if.sv | 39 +++
 rtl/rr_pick.sv | 30 +++
 rtl/mul_share_arb.sv | 116 +++++++++++
 tb/tb_mul_share_arb.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the mul_share_arb multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    // Limits of a 4-bit signed value; a product outside them cannot be truncated to 4 bits.
    localparam logic signed [OP_W-1:0] S4_MIN = -4'sd8;
    localparam logic signed [OP_W-1:0] S4_MAX = 4'sd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mul_share_arb_if.sv
// Request/response bus of mul_share_arb. MUL_SHARE_OVF_EN adds the rsp_ovf signal.
interface mul_share_arb_if
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [PROD_W-1:0]     rsp_p;
`ifdef MUL_SHARE_OVF_EN
    logic                  rsp_ovf;
`endif
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p,
`ifdef MUL_SHARE_OVF_EN
        output rsp_ovf,
`endif
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p,
`ifdef MUL_SHARE_OVF_EN
        input  rsp_ovf,
`endif
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one registered signed 4x4 multiplier among N_REQ requesters.
// Optional feature: define MUL_SHARE_OVF_EN to add the registered rsp_ovf output.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_share_arb_if.slave  bus
);

    state_t                   state_reg, state_next;
    logic [ID_W-1:0]          last_reg;
    logic [ID_W-1:0]          id_reg;
    logic signed [OP_W-1:0]   a_reg, b_reg;
    logic [PROD_W-1:0]        p_reg;
    logic                     rsp_valid_reg;
    logic                     accept;

    logic [N_REQ-1:0]         pick_grant;
    logic [ID_W-1:0]          pick_id;
    logic                     pick_any;

    logic signed [OP_W-1:0]   a_arr [N_REQ];
    logic signed [OP_W-1:0]   b_arr [N_REQ];
    logic signed [PROD_W-1:0] a_ext, b_ext, prod;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[OP_W*gi +: OP_W];
            assign b_arr[gi] = bus.req_b[OP_W*gi +: OP_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req      (bus.req_valid),
        .last     (last_reg),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    accept     = 1'b1;
                    state_next = MUL;
                end
            end
            MUL:     state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign extension to 8 bits keeps the full -56..64 range exact.
    assign a_ext = PROD_W'(a_reg);
    assign b_ext = PROD_W'(b_reg);
    assign prod  = a_ext * b_ext;

`ifdef MUL_SHARE_OVF_EN
    localparam logic signed [PROD_W-1:0] OVF_LO = PROD_W'(S4_MIN);
    localparam logic signed [PROD_W-1:0] OVF_HI = PROD_W'(S4_MAX);
    logic ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == MUL) begin
            ovf_reg <= (prod < OVF_LO) || (prod > OVF_HI);
        end
    end

    assign bus.rsp_ovf = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_reg      <= ID_W'(N_REQ - 1);
            id_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            p_reg         <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= (state_next == RESP);
            if (accept) begin
                last_reg <= pick_id;
                id_reg   <= pick_id;
                a_reg    <= a_arr[pick_id];
                b_reg    <= b_arr[pick_id];
            end
            if (state_reg == MUL) begin
                p_reg <= prod;
            end
        end
    end

    // Grants depend only on req_valid and registered state, never on rsp_ready.
    assign bus.req_ready = (state_reg == IDLE) ? pick_grant : '0;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_p     = p_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb (4 requesters).
module tb_mul_share_arb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mul_share_arb_if #(.N_REQ(4), .ID_W(2)) bus ();

    mul_share_arb #(
        .N_REQ (4),
        .ID_W  (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
        bus.req_valid[id]     = 1'b1;
        bus.req_a[4*id +: 4]  = a;
        bus.req_b[4*id +: 4]  = b;
    endtask

    task automatic clr_req(input int id);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, "_id"},    32'(bus.rsp_id),    32'd0);
        check_eq({tag, "_p"},     32'(bus.rsp_p),     32'd0);
        check_eq({tag, "_busy"},  32'(bus.busy),      32'd0);
`ifdef MUL_SHARE_OVF_EN
        check_eq({tag, "_ovf"},   32'(bus.rsp_ovf),   32'd0);
`endif
    endtask

    // Called in an IDLE cycle with the winner's request already driven.
    task automatic txn(input string tag, input int id, input logic [7:0] exp_p,
                       input logic exp_ovf, input bit keep);
        #1;
        check_eq({tag, "_grant"}, 32'(bus.req_ready), 32'(1) << id);
        step();
        if (!keep) clr_req(id);
        check_eq({tag, "_busy"},   32'(bus.busy),      32'd1);
        check_eq({tag, "_early"},  32'(bus.rsp_valid), 32'd0);
        step();
        check_eq({tag, "_valid"},  32'(bus.rsp_valid), 32'd1);
        check_eq({tag, "_p"},      32'(bus.rsp_p),     32'(exp_p));
        check_eq({tag, "_id"},     32'(bus.rsp_id),    32'(id));
`ifdef MUL_SHARE_OVF_EN
        check_eq({tag, "_ovf"},    32'(bus.rsp_ovf),   32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note %s ovf expectation undefined", tag);
`endif
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check_eq({tag, "_done"},   32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset values, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Single request: 3 * -2 = -6.
        set_req(0, 4'h3, 4'hE);
        txn("single", 0, 8'hFA, 1'b0, 1'b0);

        // Fresh reset so last = 3 and requester 0 leads the rotation.
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // All four valid continuously.
        set_req(0, 4'h2, 4'h3);   //  2 *  3 =  6
        set_req(1, 4'hF, 4'h5);   // -1 *  5 = -5
        set_req(2, 4'h7, 4'h7);   //  7 *  7 = 49
        set_req(3, 4'h8, 4'h1);   // -8 *  1 = -8
        txn("rr0", 0, 8'h06, 1'b0, 1'b1);
        txn("rr1", 1, 8'hFB, 1'b0, 1'b1);
        txn("rr2", 2, 8'h31, 1'b1, 1'b1);
        txn("rr3", 3, 8'hF8, 1'b0, 1'b1);
        txn("rr4", 0, 8'h06, 1'b0, 1'b1);
        bus.req_valid = '0;

        // Backpressure: requester 1, -3 * 4 = -12, held for 5 cycles.
        set_req(1, 4'hD, 4'h4);
        #1 check_eq("bp_grant", 32'(bus.req_ready), 32'h2);
        step();
        clr_req(1);
        step();
        set_req(1, 4'h1, 4'h8);   //  1 * -8 = -8
        set_req(2, 4'h5, 4'h5);
        set_req(3, 4'h8, 4'h8);   // -8 * -8 = 64
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("bp_p",     32'(bus.rsp_p),     32'hF4);
            check_eq("bp_id",    32'(bus.rsp_id),    32'd1);
            check_eq("bp_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        // Requester 2 gives up while waiting; with last = 1 it must be skipped.
        clr_req(2);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check_eq("bp_release_busy",  32'(bus.busy),      32'd0);
        check_eq("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        txn("skip3", 3, 8'h40, 1'b1, 1'b0);
        txn("next1", 1, 8'hF8, 1'b0, 1'b0);
        set_req(1, 4'h8, 4'h7);   // -8 * 7 = -56
        txn("ext1", 1, 8'hC8, 1'b1, 1'b0);

        // Reset while in MUL discards the transaction.
        set_req(2, 4'h2, 4'h2);
        #1 check_eq("mr_grant", 32'(bus.req_ready), 32'h4);
        step();
        clr_req(2);
        check_eq("mr_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mr_async");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_eq("mr_no_stale_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mr_idle",           32'(bus.busy),      32'd0);
        step();
        check_eq("mr_no_stale_valid2", 32'(bus.rsp_valid), 32'd0);
        set_req(0, 4'h1, 4'h1);   // 1 * 1 = 1
        set_req(1, 4'h5, 4'h5);   // 5 * 5 = 25
        txn("post0", 0, 8'h01, 1'b0, 1'b0);
        txn("post1", 1, 8'h19, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
